mm_uart_host: RTL and testbench

- Host-side initiator for the matrix-multiply UART link.
- Serialises two 4x4 matrices of 8-bit elements (A, then B) as 32 UART 8N1 frames.
- Then receives 16 result elements of 16 bits each as 32 UART frames and presents them as one parallel word.
- Used on a second FPGA or as a synthesisable stimulus/checker in front of the matrix-multiply core; contains its own bit-rate timing, transmitter and receiver.

---
 rtl/mm_uart_host.sv | 235 +++++++++++++++++++++++
 tb/tb_mm_uart_host.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_uart_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mm_uart_host: sends matrices A,B as 32 UART frames, collects 16x16b  |
// | results from 32 frames. Rev 1.0 - initial release                    |
// +----------------------------------------------------------------------+
module mm_uart_host #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int GAP_BITS     = 2,
    parameter int TIMEOUT_CLKS = 50000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] a_data,
    input  logic [127:0] b_data,
    output logic         uart_tx,
    input  logic         uart_rx,
    output logic         busy,
    output logic         done,
    output logic [255:0] result,
    output logic         frame_err,
    output logic         timeout_err
);

    localparam int c_CNT_MAX = (GAP_BITS * CLKS_PER_BIT > CLKS_PER_BIT) ?
                               GAP_BITS * CLKS_PER_BIT : CLKS_PER_BIT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_TO_W    = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_BITS * CLKS_PER_BIT - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST   = c_TO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TX_START = 4'd1,
        TX_DATA  = 4'd2,
        TX_STOP  = 4'd3,
        TX_GAP   = 4'd4,
        RX_WAIT  = 4'd5,
        RX_START = 4'd6,
        RX_DATA  = 4'd7,
        RX_STOP  = 4'd8,
        RX_HOLD  = 4'd9
    } state_t;

    state_t              state_q;
    logic [c_CNT_W-1:0]  clk_cnt_q;
    logic [c_TO_W-1:0]   to_cnt_q;
    logic [2:0]          bit_cnt_q;
    logic [4:0]          byte_cnt_q;
    logic [255:0]        tx_buf_q;
    logic [7:0]          rx_byte_q;
    logic                rx_meta_q;
    logic                rx_sync_q;
    logic                uart_tx_q;
    logic                busy_q;
    logic                done_q;
    logic [255:0]        result_q;
    logic                frame_err_q;
    logic                timeout_err_q;

    assign uart_tx     = uart_tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            clk_cnt_q     <= '0;
            to_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            tx_buf_q      <= '0;
            rx_byte_q     <= '0;
            uart_tx_q     <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tx_buf_q      <= {b_data, a_data};
                        frame_err_q   <= 1'b0;
                        timeout_err_q <= 1'b0;
                        busy_q        <= 1'b1;
                        uart_tx_q     <= 1'b0;
                        clk_cnt_q     <= '0;
                        bit_cnt_q     <= '0;
                        byte_cnt_q    <= '0;
                        state_q       <= TX_START;
                    end
                end
                TX_START: begin
                    if (clk_cnt_q == c_BIT_LAST) begin
                        clk_cnt_q <= '0;
                        uart_tx_q <= tx_buf_q[0];
                        state_q   <= TX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (clk_cnt_q == c_BIT_LAST) begin
                        clk_cnt_q <= '0;
                        tx_buf_q  <= tx_buf_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            uart_tx_q <= 1'b1;
                            state_q   <= TX_STOP;
                        end else begin
                            uart_tx_q <= tx_buf_q[1];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (clk_cnt_q == c_BIT_LAST) begin
                        clk_cnt_q <= '0;
                        state_q   <= TX_GAP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                TX_GAP: begin
                    if (clk_cnt_q == c_GAP_LAST) begin
                        clk_cnt_q <= '0;
                        if (byte_cnt_q == 5'd31) begin
                            byte_cnt_q <= '0;
                            to_cnt_q   <= '0;
                            state_q    <= RX_WAIT;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            uart_tx_q  <= 1'b0;
                            state_q    <= TX_START;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_WAIT: begin
                    if (!rx_sync_q) begin
                        to_cnt_q  <= '0;
                        clk_cnt_q <= '0;
                        state_q   <= RX_START;
                    end else if (to_cnt_q == c_TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                RX_START: begin
                    // Re-check mid start bit; a high here was only a glitch
                    if (clk_cnt_q == c_HALF_LAST) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_sync_q ? RX_WAIT : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == c_BIT_LAST) begin
                        clk_cnt_q <= '0;
                        rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == c_BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (!rx_sync_q) begin
                            frame_err_q <= 1'b1;
                        end
                        // Byte j lands at bits 8j+7:8j (elements sent low byte first)
                        result_q[{byte_cnt_q, 3'b000} +: 8] <= rx_byte_q;
                        if (byte_cnt_q == 5'd31) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= RX_HOLD;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_HOLD: begin
                    // Held-low line after a bad stop bit must not look like a new start
                    if (rx_sync_q) begin
                        state_q <= RX_WAIT;
                    end else if (to_cnt_q == c_TO_LAST) begin
                        timeout_err_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mm_uart_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mm_uart_host: scoreboard bench for mm_uart_host (8 clks/bit).     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mm_uart_host;

    localparam int CPB = 8;
    localparam int GAP = 2;
    localparam int TOC = 2000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] a_data = '0;
    logic [127:0] b_data = '0;
    logic         uart_tx;
    logic         uart_rx = 1'b1;
    logic         busy;
    logic         done;
    logic [255:0] result;
    logic         frame_err;
    logic         timeout_err;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int e0       = 0;
    bit tx_mon_en = 1'b1;

    logic [7:0]   tx_exp[$];
    logic [255:0] res_exp[$];

    mm_uart_host #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (GAP),
        .TIMEOUT_CLKS(TOC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_data     (a_data),
        .b_data     (b_data),
        .uart_tx    (uart_tx),
        .uart_rx    (uart_rx),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .frame_err  (frame_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < e0 + n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic push_tx(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] buf_v;
        buf_v = {b, a};
        for (int i = 0; i < 32; i++) tx_exp.push_back(buf_v[8*i +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // TX monitor: decode every frame on uart_tx and pop the expected byte
    initial forever begin
        logic [7:0] rb;
        logic       sb;
        @(posedge clk);
        #1;
        if (rst === 1'b1 && uart_tx === 1'b0) begin
            repeat (3) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1;
                rb[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            #1;
            sb = uart_tx;
            if (tx_mon_en) begin
                if (tx_exp.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL tx_extra: got frame %h expected no frame", rb);
                end else begin
                    chk("tx_byte", {248'd0, rb}, {248'd0, tx_exp.pop_front()});
                    chk("tx_stop", {255'd0, sb}, 256'd1);
                end
            end
        end
    end

    // Result monitor: every done pulse pops one expected result word
    initial forever begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (res_exp.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL done_extra: got done=1 expected no done");
            end else begin
                chk("result", result, res_exp.pop_front());
                chk("busy_at_done", {255'd0, busy}, 256'd0);
            end
        end
    end

    initial begin
        logic [9:0]   fr;
        logic [255:0] r;

        // Reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx", {255'd0, uart_tx}, 256'd1);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_result", result, 256'd0);
        chk("rst_ferr", {255'd0, frame_err}, 256'd0);
        chk("rst_terr", {255'd0, timeout_err}, 256'd0);
        @(negedge clk);
        rst = 1'b1;

        // Test 1: A0=A5, no response -> timeout
        a_data = 128'h0;
        a_data[7:0] = 8'hA5;
        b_data = 128'h0;
        push_tx(a_data, b_data);
        pulse_start();
        chk("start_busy", {255'd0, busy}, 256'd1);
        chk("start_tx_low", {255'd0, uart_tx}, 256'd0);
        fr = 10'b1101001010;
        for (int i = 0; i < 10; i++) begin
            wait_to(4 + CPB * i);
            chk($sformatf("frame0_bit%0d", i), {255'd0, uart_tx}, {255'd0, fr[i]});
        end
        wait_to(32 * (10 + GAP) * CPB + TOC - 1);
        chk("pre_timeout", {255'd0, timeout_err}, 256'd0);
        chk("pre_timeout_busy", {255'd0, busy}, 256'd1);
        wait_to(32 * (10 + GAP) * CPB + TOC);
        chk("timeout_err", {255'd0, timeout_err}, 256'd1);
        chk("timeout_busy", {255'd0, busy}, 256'd0);
        repeat (10) @(negedge clk);

        // Test 2: full loopback, element k = 0x0100 + k
        for (int k = 0; k < 16; k++) begin
            a_data[8*k +: 8] = 8'h10 + 8'(k);
            b_data[8*k +: 8] = 8'h80 + 8'(k);
        end
        push_tx(a_data, b_data);
        for (int k = 0; k < 16; k++) r[16*k +: 16] = 16'h0100 + 16'(k);
        res_exp.push_back(r);
        pulse_start();
        chk("terr_cleared", {255'd0, timeout_err}, 256'd0);
        wait_to(32 * (10 + GAP) * CPB + 10);
        for (int j = 0; j < 32; j++)
            send_byte((j % 2 == 0) ? 8'(j / 2) : 8'h01, 1'b1);
        repeat (20) @(negedge clk);
        chk("done_count_1", 256'(done_cnt), 256'd1);
        chk("res_lo", {240'd0, result[15:0]}, {240'd0, 16'h0100});
        chk("res_hi", {240'd0, result[255:240]}, {240'd0, 16'h010F});
        chk("ferr_clean", {255'd0, frame_err}, 256'd0);

        // Test 3: glitch rejected, frame 5 with bad stop bit
        a_data = 128'h0;
        b_data = 128'h0;
        push_tx(a_data, b_data);
        for (int j = 0; j < 32; j++) r[8*j +: 8] = 8'h30 + 8'(j);
        res_exp.push_back(r);
        pulse_start();
        wait_to(32 * (10 + GAP) * CPB + 10);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (16) @(negedge clk);
        chk("glitch_busy", {255'd0, busy}, 256'd1);
        chk("glitch_ferr", {255'd0, frame_err}, 256'd0);
        chk("glitch_nostore", {240'd0, result[15:0]}, {240'd0, 16'h0100});
        for (int j = 0; j < 32; j++)
            send_byte(8'h30 + 8'(j), (j == 5) ? 1'b0 : 1'b1);
        repeat (20) @(negedge clk);
        chk("ferr_set", {255'd0, frame_err}, 256'd1);
        chk("done_count_2", 256'(done_cnt), 256'd2);

        // Test 4: start while busy ignored, reset during frame 3
        for (int k = 0; k < 16; k++) a_data[8*k +: 8] = 8'h11 * 8'(k + 1);
        b_data = 128'h0;
        for (int i = 0; i < 3; i++) tx_exp.push_back(a_data[8*i +: 8]);
        pulse_start();
        wait_to(100);
        start = 1'b1;
        wait_to(101);
        start = 1'b0;
        chk("busy_start_ignored", {255'd0, busy}, 256'd1);
        wait_to(280);
        tx_mon_en = 1'b0;
        wait_to(3 * (10 + GAP) * CPB + 2);
        chk("frame3_start_low", {255'd0, uart_tx}, 256'd0);
        rst = 1'b0;
        wait_to(3 * (10 + GAP) * CPB + 3);
        chk("midrst_tx", {255'd0, uart_tx}, 256'd1);
        chk("midrst_busy", {255'd0, busy}, 256'd0);
        chk("midrst_result", result, 256'd0);
        rst = 1'b1;
        wait_to(450);
        tx_mon_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_rst", {255'd0, uart_tx}, 256'd1);

        chk("tx_queue_empty", 256'(tx_exp.size()), 256'd0);
        chk("res_queue_empty", 256'(res_exp.size()), 256'd0);
        chk("done_total", 256'(done_cnt), 256'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
